// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter over per-FU result FIFOs with mispredict squash
// Optional macro CDB_BYPASS_EN: a source with no live buffered result may be granted straight from its inputs.
module cdb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int PREG_W     = 7,
  parameter int ROB_W      = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [PREG_W-1:0] alu_pd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [ROB_W-1:0]  alu_tag,
  output logic              alu_ready,
  input  logic              b_valid,
  input  logic [PREG_W-1:0] b_pd,
  input  logic [DATA_W-1:0] b_data,
  input  logic [ROB_W-1:0]  b_tag,
  output logic              b_ready,
  input  logic              mem_valid,
  input  logic [PREG_W-1:0] mem_pd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ROB_W-1:0]  mem_tag,
  output logic              mem_ready,
  input  logic [ROB_W-1:0]  rob_head,
  input  logic              mispredict,
  input  logic [ROB_W-1:0]  mispredict_tag,
  input  logic              cdb_ready,
  output logic              cdb_valid,
  output logic [PREG_W-1:0] cdb_pd,
  output logic [DATA_W-1:0] cdb_data,
  output logic [ROB_W-1:0]  cdb_tag,
  output logic [1:0]        cdb_src
);

  localparam int NSRC  = 3;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Ages are distances from the ROB head, so the compare survives tag wrap-around.
  function automatic logic is_younger(input logic mp, input logic [ROB_W-1:0] t,
                                      input logic [ROB_W-1:0] head, input logic [ROB_W-1:0] mtag);
    logic [ROB_W-1:0] age_t;
    logic [ROB_W-1:0] age_m;
    age_t = t - head;
    age_m = mtag - head;
    return mp && (age_t > age_m);
  endfunction

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  logic [NSRC-1:0]   in_valid, in_ready, cand, push, pop, take;
  logic [PREG_W-1:0] in_pd   [NSRC];
  logic [DATA_W-1:0] in_data [NSRC];
  logic [ROB_W-1:0]  in_tag  [NSRC];
  logic [PREG_W-1:0] sel_pd  [NSRC];
  logic [DATA_W-1:0] sel_data[NSRC];
  logic [ROB_W-1:0]  sel_tag [NSRC];
  logic [1:0]        rr_q, gnt;
  logic              gnt_any;

  assign in_valid   = {mem_valid, b_valid, alu_valid};
  assign in_pd[0]   = alu_pd;
  assign in_pd[1]   = b_pd;
  assign in_pd[2]   = mem_pd;
  assign in_data[0] = alu_data;
  assign in_data[1] = b_data;
  assign in_data[2] = mem_data;
  assign in_tag[0]  = alu_tag;
  assign in_tag[1]  = b_tag;
  assign in_tag[2]  = mem_tag;
  assign {mem_ready, b_ready, alu_ready} = in_ready;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [FIFO_DEPTH-1:0] live_q, live_d;
    logic [PREG_W-1:0]     pd_q   [FIFO_DEPTH];
    logic [DATA_W-1:0]     data_q [FIFO_DEPTH];
    logic [ROB_W-1:0]      tag_q  [FIFO_DEPTH];
    logic                  head_cand, head_dead, in_live;

    assign in_ready[s] = count < CNT_W'(FIFO_DEPTH);
    assign in_live     = !is_younger(mispredict, in_tag[s], rob_head, mispredict_tag);
    assign head_cand   = live_q[rd_ptr] && !is_younger(mispredict, tag_q[rd_ptr], rob_head, mispredict_tag);
    assign head_dead   = (count != '0) && !live_q[rd_ptr];
    assign take[s]     = gnt_any && cdb_ready && (gnt == 2'(s));

`ifdef CDB_BYPASS_EN
    logic byp;
    assign byp         = (live_q == '0) && in_valid[s] && in_ready[s] && in_live;
    assign cand[s]     = head_cand || byp;
    assign sel_pd[s]   = byp ? in_pd[s]   : pd_q[rd_ptr];
    assign sel_data[s] = byp ? in_data[s] : data_q[rd_ptr];
    assign sel_tag[s]  = byp ? in_tag[s]  : tag_q[rd_ptr];
    assign push[s]     = in_valid[s] && in_ready[s] && !(byp && take[s]);
    assign pop[s]      = head_dead || (take[s] && !byp);
`else
    assign cand[s]     = head_cand;
    assign sel_pd[s]   = pd_q[rd_ptr];
    assign sel_data[s] = data_q[rd_ptr];
    assign sel_tag[s]  = tag_q[rd_ptr];
    assign push[s]     = in_valid[s] && in_ready[s];
    assign pop[s]      = head_dead || take[s];
`endif

    // Live bits are cleared on pop, so a set bit always marks an occupied slot.
    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_ent
      assign live_d[i] = (push[s] && (wr_ptr == PTR_W'(i))) ? in_live :
                         (pop[s]  && (rd_ptr == PTR_W'(i))) ? 1'b0 :
                         (live_q[i] && !is_younger(mispredict, tag_q[i], rob_head, mispredict_tag));
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        live_q <= '0;
      end else begin
        live_q <= live_d;
        if (push[s]) begin
          pd_q[wr_ptr]   <= in_pd[s];
          data_q[wr_ptr] <= in_data[s];
          tag_q[wr_ptr]  <= in_tag[s];
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop[s]) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push[s]) - CNT_W'(pop[s]);
      end
    end
  end

  always_comb begin
    logic [1:0] s1, s2;
    s1  = next_src(rr_q);
    s2  = next_src(s1);
    gnt = s2;
    if (cand[rr_q])    gnt = rr_q;
    else if (cand[s1]) gnt = s1;
  end

  assign gnt_any   = |cand;
  assign cdb_valid = gnt_any;
  assign cdb_src   = gnt_any ? (gnt + 2'd1) : 2'd0;
  assign cdb_pd    = gnt_any ? sel_pd[gnt]   : '0;
  assign cdb_data  = gnt_any ? sel_data[gnt] : '0;
  assign cdb_tag   = gnt_any ? sel_tag[gnt]  : '0;

  always_ff @(posedge clk) begin
    if (!reset)                     rr_q <= 2'd0;
    else if (gnt_any && cdb_ready)  rr_q <= next_src(gnt);
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
  localparam int DATA_W = 32;
  localparam int PREG_W = 7;
  localparam int ROB_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid, b_valid, mem_valid;
  logic [PREG_W-1:0] alu_pd, b_pd, mem_pd;
  logic [DATA_W-1:0] alu_data, b_data, mem_data;
  logic [ROB_W-1:0]  alu_tag, b_tag, mem_tag;
  logic              alu_ready, b_ready, mem_ready;
  logic [ROB_W-1:0]  rob_head, mispredict_tag;
  logic              mispredict, cdb_ready;
  logic              cdb_valid;
  logic [PREG_W-1:0] cdb_pd;
  logic [DATA_W-1:0] cdb_data;
  logic [ROB_W-1:0]  cdb_tag;
  logic [1:0]        cdb_src;

  cdb_arbiter #(.DATA_W(DATA_W), .PREG_W(PREG_W), .ROB_W(ROB_W), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_pd(alu_pd), .alu_data(alu_data), .alu_tag(alu_tag), .alu_ready(alu_ready),
    .b_valid(b_valid), .b_pd(b_pd), .b_data(b_data), .b_tag(b_tag), .b_ready(b_ready),
    .mem_valid(mem_valid), .mem_pd(mem_pd), .mem_data(mem_data), .mem_tag(mem_tag), .mem_ready(mem_ready),
    .rob_head(rob_head), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .cdb_ready(cdb_ready), .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_data(cdb_data),
    .cdb_tag(cdb_tag), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PREG_W-1:0] pd;
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  tag;
  } res_t;

  res_t  exp_q [3][$];
  string src_nm [3] = '{"cdb_alu", "cdb_br", "cdb_mem"};
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic bit squashed(input logic [4:0] t, input logic [4:0] head, input logic [4:0] mtag);
    int at, am;
    at = (int'(t) - int'(head) + 32) % 32;
    am = (int'(mtag) - int'(head) + 32) % 32;
    return at > am;
  endfunction

  // Scoreboard: accepted pushes queue up per source; every broadcast must match its source's head.
  always @(negedge clk) begin
    int   s;
    res_t got;
    res_t keep[$];
    if (!reset) begin
      for (int k = 0; k < 3; k++) exp_q[k].delete();
    end else begin
      if (cdb_valid) begin
        got = {cdb_pd, cdb_data, cdb_tag};
        if (cdb_src == 2'd0) check("cdb_src_none", 64'(cdb_src), 64'(1));
        else begin
          s = int'(cdb_src) - 1;
          if (exp_q[s].size() == 0) check("cdb_unexpected_src", 64'(cdb_src), 64'(0));
          else begin
            check(src_nm[s], 64'(got), 64'(exp_q[s][0]));
            if (cdb_ready) void'(exp_q[s].pop_front());
          end
        end
      end
      if (alu_valid && alu_ready) exp_q[0].push_back({alu_pd, alu_data, alu_tag});
      if (b_valid   && b_ready)   exp_q[1].push_back({b_pd, b_data, b_tag});
      if (mem_valid && mem_ready) exp_q[2].push_back({mem_pd, mem_data, mem_tag});
      if (mispredict) begin
        for (int k = 0; k < 3; k++) begin
          keep.delete();
          for (int i = 0; i < exp_q[k].size(); i++)
            if (!squashed(exp_q[k][i].tag, rob_head, mispredict_tag)) keep.push_back(exp_q[k][i]);
          exp_q[k] = keep;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic [PREG_W-1:0] pd, input logic [DATA_W-1:0] d,
                       input logic [ROB_W-1:0] t);
    case (s)
      0: begin alu_valid = 1'b1; alu_pd = pd; alu_data = d; alu_tag = t; end
      1: begin b_valid   = 1'b1; b_pd   = pd; b_data   = d; b_tag   = t; end
      default: begin mem_valid = 1'b1; mem_pd = pd; mem_data = d; mem_tag = t; end
    endcase
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    b_valid   = 1'b0;
    mem_valid = 1'b0;
  endtask

  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
  endfunction

  // Call right after cyc(); ends just after a falling edge.
  task automatic drain(input string nm);
    int n;
    n = 0;
    idle();
    cdb_ready = 1'b1;
    while (n < 60 && pending() != 0) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(nm, 64'(pending()), 64'(0));
    @(negedge clk);
    check({nm, "_idle"}, 64'(cdb_valid), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int br_cycle, viol, prev, br_cnt;
    reset = 1'b0; cdb_ready = 1'b1; mispredict = 1'b0; mispredict_tag = '0; rob_head = '0;
    idle();
    alu_pd = '0; alu_data = '0; alu_tag = '0; b_pd = '0; b_data = '0; b_tag = '0;
    mem_pd = '0; mem_data = '0; mem_tag = '0;

    // Reset held for two edges with a pending ALU result
    drive(0, 7'd9, 32'hDEAD, 5'd9);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    @(negedge clk);
    check("rst_valid", 64'(cdb_valid), 64'(0));
    check("rst_src", 64'(cdb_src), 64'(0));
    check("rst_ready", 64'({alu_ready, b_ready, mem_ready}), 64'(3'b111));
    check("rst_bus", 64'({cdb_pd, cdb_data, cdb_tag}), 64'(0));
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      check("rst_quiet", 64'(cdb_valid), 64'(0));
    end

    // Three sources at once: ALU, BR, MEM in order; MEM carries pd 0
    cyc();
    drive(0, 7'd10, 32'hA1, 5'd3);
    drive(1, 7'd11, 32'hB1, 5'd4);
    drive(2, 7'd0,  32'hC1, 5'd5);
    cyc();
    idle();
    @(negedge clk);
    check("rr_src0", 64'(cdb_src), 64'(2'b01));
    check("rr_tag0", 64'(cdb_tag), 64'(3));
    cyc();
    @(negedge clk);
    check("rr_src1", 64'(cdb_src), 64'(2'b10));
    check("rr_tag1", 64'(cdb_tag), 64'(4));
    cyc();
    @(negedge clk);
    check("rr_src2", 64'(cdb_src), 64'(2'b11));
    check("rr_pd0", 64'(cdb_pd), 64'(0));
    cyc();
    @(negedge clk);
    check("rr_empty", 64'(cdb_valid), 64'(0));
    cyc();
    drive(0, 7'd12, 32'hA2, 5'd6);
    drive(1, 7'd13, 32'hB2, 5'd7);
    cyc();
    idle();
    @(negedge clk);
    check("rr_wrap_alu", 64'(cdb_src), 64'(2'b01));
    cyc();
    @(negedge clk);
    check("rr_wrap_br", 64'(cdb_src), 64'(2'b10));
    cyc();
    drain("drain_rr");

    // Downstream stall: ALU fills after two pushes, head held stable
    cyc();
    cdb_ready = 1'b0;
    drive(0, 7'd20, 32'h100, 5'd8);
    @(negedge clk);
    check("stall_rdy0", 64'(alu_ready), 64'(1));
    cyc();
    drive(0, 7'd21, 32'h101, 5'd9);
    @(negedge clk);
    check("stall_rdy1", 64'(alu_ready), 64'(1));
    check("stall_head1", 64'(cdb_tag), 64'(8));
    cyc();
    drive(0, 7'd22, 32'h102, 5'd10);
    @(negedge clk);
    check("stall_full", 64'(alu_ready), 64'(0));
    check("stall_head2", 64'(cdb_data), 64'(32'h100));
    cyc();
    @(negedge clk);
    check("stall_full2", 64'(alu_ready), 64'(0));
    check("stall_head3", 64'(cdb_tag), 64'(8));
    cyc();
    cdb_ready = 1'b1;
    @(negedge clk);
    check("stall_release", 64'(cdb_tag), 64'(8));
    cyc();
    @(negedge clk);
    check("stall_rdy_after_pop", 64'(alu_ready), 64'(1));
    check("stall_next", 64'(cdb_tag), 64'(9));
    cyc();
    drain("drain_stall");

    // Mispredict with head wrap: rob_head 30, squash tag 1 keeps 31 and 1, kills 2
    cyc();
    cdb_ready = 1'b0;
    rob_head = 5'd30;
    drive(0, 7'd30, 32'h31, 5'd31);
    drive(1, 7'd31, 32'h01, 5'd1);
    drive(2, 7'd32, 32'h02, 5'd2);
    cyc();
    idle();
    mispredict = 1'b1;
    mispredict_tag = 5'd1;
    drive(0, 7'd33, 32'h03, 5'd3);
    @(negedge clk);
    check("mp_valid", 64'(cdb_valid), 64'(1));
    check("mp_not_mem", 64'(cdb_src == 2'b11), 64'(0));
    cyc();
    mispredict = 1'b0;
    idle();
    @(negedge clk);
    check("mp_after_not_mem", 64'(cdb_src == 2'b11), 64'(0));
    cyc();
    drain("drain_mp");
    check("mp_mem_ready", 64'(mem_ready), 64'(1));
    rob_head = '0;

    // Starvation: ALU and MEM stream, BR pushes once at cycle 4
    br_cycle = -1; viol = 0; prev = 0; br_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      cyc();
      cdb_ready = 1'b1;
      drive(0, 7'(40 + c), $urandom, 5'(c));
      drive(2, 7'(60 + c), $urandom, 5'(c));
      b_valid = 1'b0;
      if (c == 4) drive(1, 7'd50, 32'hB5, 5'd4);
      @(negedge clk);
      if (cdb_valid && cdb_src == 2'b10) begin
        br_cnt++;
        if (br_cycle < 0) br_cycle = c;
      end else if (cdb_valid) begin
        if (int'(cdb_src) == prev) viol++;
        prev = int'(cdb_src);
      end
    end
    check("starve_br_count", 64'(br_cnt), 64'(1));
    check("starve_br_latency", 64'(br_cycle >= 5 && br_cycle <= 7), 64'(1));
    check("starve_alternate", 64'(viol), 64'(0));
    cyc();
    drain("drain_starve");

    // All FIFOs full, then a one-edge reset mid-stream
    cyc();
    cdb_ready = 1'b0;
    drive(0, 7'd70, 32'h700, 5'd1);
    drive(1, 7'd71, 32'h710, 5'd2);
    drive(2, 7'd72, 32'h720, 5'd3);
    cyc();
    drive(0, 7'd73, 32'h701, 5'd4);
    drive(1, 7'd74, 32'h711, 5'd5);
    drive(2, 7'd75, 32'h721, 5'd6);
    cyc();
    idle();
    @(negedge clk);
    check("full_ready", 64'({alu_ready, b_ready, mem_ready}), 64'(0));
    cyc();
    reset = 1'b0;
    cdb_ready = 1'b1;
    cyc();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 64'(cdb_valid), 64'(0));
    check("mid_rst_src", 64'(cdb_src), 64'(0));
    check("mid_rst_ready", 64'({alu_ready, b_ready, mem_ready}), 64'(3'b111));
    cyc();
    cdb_ready = 1'b0;
    drive(0, 7'd80, 32'h800, 5'd7);
    cyc();
    drive(0, 7'd81, 32'h801, 5'd8);
    @(negedge clk);
    check("mid_rst_cnt1", 64'(alu_ready), 64'(1));
    check("mid_rst_fresh", 64'(cdb_data), 64'(32'h800));
    cyc();
    idle();
    @(negedge clk);
    check("mid_rst_cnt2", 64'(alu_ready), 64'(0));
    cyc();
    drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) / PRF write-back port among the three functional units (ALU, branch, memory) that sit behind the dispatch reservation stations.
- Each FU completion is buffered in a small per-source FIFO.
- One result per cycle is granted round-robin and broadcast as pd/value/ROB tag to the PRF, the ready table and the ROB.
- Results younger than a mispredicted branch are squashed.

Parameters:
DATA_W, 32, result value width
PREG_W, 7, physical register index width (128 pregs)
ROB_W, 5, ROB tag width (32 entries)
FIFO_DEPTH, 2, entries per source FIFO; power of two, >=2

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
alu_valid/b_valid/mem_valid  in  1 each  FU result valid
alu_pd/b_pd/mem_pd  in  PREG_W each  destination preg
alu_data/b_data/mem_data  in  DATA_W each  result value
alu_tag/b_tag/mem_tag  in  ROB_W each  ROB index of result
alu_ready/b_ready/mem_ready  out  1 each  source FIFO can accept
rob_head  in  ROB_W  oldest ROB entry, used for age compare
mispredict  in  1  branch mispredict pulse
mispredict_tag  in  ROB_W  ROB tag of mispredicted branch
cdb_ready  in  1  downstream write port free this cycle
cdb_valid  out  1  broadcast valid
cdb_pd  out  PREG_W  broadcast preg
cdb_data  out  DATA_W  broadcast value
cdb_tag  out  ROB_W  broadcast ROB tag
cdb_src  out  2  granted source: 01 ALU, 10 BR, 11 MEM, 00 none

Behaviour:
- Reset (reset==0 at clock edge): all FIFOs empty, all entry-valid bits 0, RR pointer = ALU, cdb_valid=0, cdb_src=00, cdb_pd/data/tag=0, all *_ready=1. Reset overrides any push, pop or flush in the same cycle.
- Push: x_valid && x_ready at edge writes {pd,data,tag,live=1} at the tail. x_ready = (count < FIFO_DEPTH). No push-through-when-full.
- Candidates: a source is a candidate when its head exists and is live.
- Dead heads: a dead head (live=0) is popped silently that cycle, with no grant, regardless of cdb_ready.
- Grant, combinational: the first candidate at or after the RR pointer in order ALU→BR→MEM (wrapping) drives cdb_* and cdb_src.
- cdb_valid = any candidate after the mispredict mask below; cdb_* = 0 when not valid.
- Pop and pointer update: when cdb_valid && cdb_ready, the granted head pops and the RR pointer moves to the source after the granted one.
- Downstream stall: cdb_ready=0 leaves the FIFO and pointer unchanged; cdb_* stays stable while inputs are unchanged.
- Latency: a result pushed at edge N is eligible from cycle N+1 (registered FIFO, no bypass).
- Age: age(t) = (t − rob_head) mod 2^ROB_W. Tag t is younger than the mispredict when age(t) > age(mispredict_tag).
- Mispredict cycle:
  - Every stored entry that is younger has live cleared at the edge.
  - A younger entry pushed in the same cycle is stored dead.
  - A younger head is masked from the grant that cycle; it is not broadcast and not popped as granted.
  - Entries with tag equal to or older than mispredict_tag are unaffected.
- pd==0: still broadcast, so the ROB sees completion; consumers ignore the pd.
- Simultaneous push and pop on the same FIFO: allowed when not full, count unchanged.
- FIFO pointers wrap mod FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

Optional Feature:
CDB_BYPASS_EN
- When defined: a source whose FIFO is empty (or holds only dead entries) can present its incoming x_valid result as a candidate in the same cycle.
  - If granted with cdb_ready=1, it is consumed without being written, giving 0-cycle latency.
  - If not granted, it is pushed normally.
  - The mispredict mask applies to bypassed results too.
- When undefined: minimum latency is 1 cycle as above.

Test Plan:
- Hold reset=0 for 2 edges while alu_valid=1 → after release: cdb_valid=0, all *_ready=1, cdb_src=00, nothing from the reset cycles broadcast.
- Push ALU tag 3, BR tag 4, MEM tag 5 in the same cycle, cdb_ready=1 → cdb_src 01/tag 3, 10/tag 4, 11/tag 5 on three consecutive cycles, starting the next cycle (same cycle if CDB_BYPASS_EN). The RR pointer then returns to ALU.
- cdb_ready=0, push ALU 3 times → alu_ready=0 after the 2nd push, the 3rd is not accepted, cdb_* holds the first entry stable. Raise cdb_ready → alu_ready=1 the cycle after the first pop.
- rob_head=30, FIFO entries tags 31 (ALU), 1 (BR), 2 (MEM), mispredict=1 with mispredict_tag=1 → tag 2 is never broadcast, tags 31 and 1 are broadcast (wrap-around age check), MEM FIFO drains empty.
- Starvation: ALU and MEM push every cycle, BR pushes once → BR is granted within 3 cycles of becoming a candidate, and grants alternate ALU/MEM otherwise.
- All FIFOs full, reset=0 for one edge mid-stream → next cycle cdb_valid=0, all counts 0, no stale result ever appears on the CDB.
